// File: rtl/des_key_schedule_seq.sv
// Sequential DES/3DES key scheduler: streams one PC-2 subkey per valid/ready transfer.
// Define DES_KS_PARITY_CHECK_EN to enable odd-parity checking of the latched keys.
module des_key_schedule_seq #(
  parameter int unsigned NUM_KEYS = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic [64*NUM_KEYS-1:0] key_i,
  output logic                   busy_o,
  output logic [47:0]            subkey_o,
  output logic                   subkey_valid_o,
  input  logic                   subkey_ready_i,
  output logic [3:0]             sk_num_o,
  output logic [1:0]             sk_stage_o,
  output logic                   sk_dir_o,
  output logic                   sk_last_o,
  output logic                   done_o,
  output logic                   parity_err_o
);

  if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_num_keys
    $error("des_key_schedule_seq: NUM_KEYS must be 1 or 3");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StEmit, StDone} state_e;

  localparam logic [1:0] LastStage = 2'(NUM_KEYS - 1);

  localparam int unsigned Pc1Tbl [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned Pc2Tbl [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Tables use DES numbering (bit 1 = MSB); vectors here are [N-1:0] with MSB = bit 1.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - Pc1Tbl[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - Pc2Tbl[i])];
    return o;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Round n (1..16) shifts by two except rounds 1, 2, 9 and 16.
  function automatic logic shift2(input logic [4:0] n);
    return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
  endfunction

  state_e                  state_q, state_d;
  logic [64*NUM_KEYS-1:0]  key_q, key_d;
  logic                    mode_q, mode_d;
  logic [27:0]             c_q, c_d, d_q, d_d;
  logic [3:0]              r_q, r_d;
  logic [1:0]              stage_q, stage_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [63:0]             stage_key;
  logic                    dir;
  logic [55:0]             ld_cd;

  if (NUM_KEYS == 3) begin : g_triple
    // EDE: middle stage runs the opposite direction; decrypt walks the keys backwards.
    logic [1:0] key_idx;
    assign key_idx = mode_q ? 2'd2 - stage_q : stage_q;
    assign dir     = mode_q ^ stage_q[0];
    always_comb begin
      case (key_idx)
        2'd0:    stage_key = key_q[191:128];
        2'd1:    stage_key = key_q[127:64];
        default: stage_key = key_q[63:0];
      endcase
    end
  end else begin : g_single
    assign dir       = mode_q;
    assign stage_key = key_q[63:0];
  end

  assign ld_cd = pc1(stage_key);

`ifdef DES_KS_PARITY_CHECK_EN
  logic [8*NUM_KEYS-1:0] byte_odd;
  logic                  parity_bad;
  logic                  perr_q, perr_d;
  for (genvar g = 0; g < 8 * NUM_KEYS; g++) begin : g_parity
    assign byte_odd[g] = ^key_q[8*g +: 8];
  end
  assign parity_bad = ~&byte_odd;
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    mode_d  = mode_q;
    c_d     = c_q;
    d_d     = d_q;
    r_d     = r_q;
    stage_d = stage_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DES_KS_PARITY_CHECK_EN
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          key_d   = key_i;
          mode_d  = mode_i;
          stage_d = '0;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Decrypt presents K16 first, which is the unrotated C0/D0.
        r_d     = '0;
        c_d     = dir ? ld_cd[55:28] : rotl(ld_cd[55:28], 1'b0);
        d_d     = dir ? ld_cd[27:0]  : rotl(ld_cd[27:0], 1'b0);
        state_d = StEmit;
`ifdef DES_KS_PARITY_CHECK_EN
        if (stage_q == 2'd0 && parity_bad) begin
          perr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
`endif
      end
      StEmit: begin
        if (subkey_ready_i) begin
          if (r_q != 4'd15) begin
            r_d = r_q + 4'd1;
            if (dir) begin
              c_d = rotr(c_q, shift2(5'd16 - {1'b0, r_q}));
              d_d = rotr(d_q, shift2(5'd16 - {1'b0, r_q}));
            end else begin
              c_d = rotl(c_q, shift2({1'b0, r_q} + 5'd2));
              d_d = rotl(d_q, shift2({1'b0, r_q} + 5'd2));
            end
          end else if (stage_q != LastStage) begin
            stage_d = stage_q + 2'd1;
            state_d = StLoad;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      key_q   <= '0;
      mode_q  <= 1'b0;
      c_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      d_q     <= d_d;
      r_q     <= r_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DES_KS_PARITY_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perr_q <= 1'b0;
    else         perr_q <= perr_d;
  end
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign subkey_o       = pc2({c_q, d_q});
  assign subkey_valid_o = (state_q == StEmit);
  assign sk_num_o       = dir ? 4'd15 - r_q : r_q;
  assign sk_stage_o     = stage_q;
  assign sk_dir_o       = dir;
  assign sk_last_o      = subkey_valid_o && (stage_q == LastStage) && (r_q == 4'd15);

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Scoreboard bench for des_key_schedule_seq: single-DES and 3DES instances checked
// against a cumulative-shift reference model of the key schedule.
module tb_des_key_schedule_seq;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  num;
    logic [1:0]  stg;
    logic        dir;
    logic        last;
  } exp_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

`ifdef DES_KS_PARITY_CHECK_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  logic clk, rst_n, start, mode, ready, sel3;
  logic [63:0] k1v, k2v, k3v;
  logic        busy1, v1, dir1, last1, done1, perr1;
  logic [47:0] sk1;
  logic [3:0]  num1;
  logic [1:0]  stg1;
  logic        busy3, v3, dir3, last3, done3, perr3;
  logic [47:0] sk3;
  logic [3:0]  num3;
  logic [1:0]  stg3;

  des_key_schedule_seq #(.NUM_KEYS(1)) u_des1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start & ~sel3), .mode_i(mode), .key_i(k1v),
    .busy_o(busy1), .subkey_o(sk1), .subkey_valid_o(v1), .subkey_ready_i(ready),
    .sk_num_o(num1), .sk_stage_o(stg1), .sk_dir_o(dir1), .sk_last_o(last1),
    .done_o(done1), .parity_err_o(perr1));

  des_key_schedule_seq #(.NUM_KEYS(3)) u_des3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start & sel3), .mode_i(mode),
    .key_i({k1v, k2v, k3v}),
    .busy_o(busy3), .subkey_o(sk3), .subkey_valid_o(v3), .subkey_ready_i(ready),
    .sk_num_o(num3), .sk_stage_o(stg3), .sk_dir_o(dir3), .sk_last_o(last3),
    .done_o(done3), .parity_err_o(perr3));

  logic [55:0] cur_tup;
  logic        cur_valid, cur_done, cur_perr, cur_busy;
  logic [59:0] all1, all3;
  assign cur_tup   = sel3 ? {sk3, num3, stg3, dir3, last3} : {sk1, num1, stg1, dir1, last1};
  assign cur_valid = sel3 ? v3 : v1;
  assign cur_done  = sel3 ? done3 : done1;
  assign cur_perr  = sel3 ? perr3 : perr1;
  assign cur_busy  = sel3 ? busy3 : busy1;
  assign all1 = {busy1, sk1, v1, num1, stg1, dir1, last1, done1, perr1};
  assign all3 = {busy3, sk3, v3, num3, stg3, dir3, last3, done3, perr3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          ncmp = 0;
  int          nerr = 0;
  exp_t        q[$];
  logic [47:0] got[$];
  logic [55:0] prev_tup;
  bit          prev_stall;
  bit          seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: K_n = PC2 of C0/D0 rotated left by the cumulative shift through round n.
  function automatic logic [47:0] ref_sk(input logic [63:0] k, input int n);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] o;
    int tot = 0;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1[i])];
    for (int j = 1; j <= n; j++) tot += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
    tot = tot % 28;
    c = cd[55:28];
    d = cd[27:0];
    c = (c << tot) | (c >> (28 - tot));
    d = (d << tot) | (d >> (28 - tot));
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return o;
  endfunction

  task automatic push_sched(input bit n3, input logic [63:0] ka, kb, kc, input logic m);
    int ns = n3 ? 3 : 1;
    for (int s = 0; s < ns; s++) begin
      logic [63:0] kk;
      logic        dr;
      exp_t        e;
      if (!n3) begin
        kk = ka; dr = m;
      end else begin
        dr = m ^ (s == 1);
        if (m) kk = (s == 0) ? kc : (s == 1) ? kb : ka;
        else   kk = (s == 0) ? ka : (s == 1) ? kb : kc;
      end
      for (int j = 0; j < 16; j++) begin
        int n = dr ? 16 - j : j + 1;
        e.sk   = ref_sk(kk, n);
        e.num  = 4'(n - 1);
        e.stg  = 2'(s);
        e.dir  = dr;
        e.last = (s == ns - 1) && (j == 15);
        q.push_back(e);
      end
    end
  endtask

  function automatic logic rdy(input int pat, input int idx);
    logic [5:0] p;
    p = 6'b101001;
    if (pat == 1) return p[3'(idx % 6)];
    if (pat == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] rand_key();
    logic [63:0] k;
    k = {$urandom, $urandom};
    for (int b = 0; b < 8; b++) k[8*b] = ~^k[8*b+7 -: 7];
    return k;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_while_stalled", {7'b0, cur_valid, cur_tup}, {8'h01, prev_tup});
      if (cur_valid && ready) begin
        if (q.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL extra_subkey: got %h, required no transfer", cur_tup[55:8]);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("subkey_stream", 64'(cur_tup), 64'(e));
          got.push_back(cur_tup[55:8]);
        end
      end
      prev_stall = cur_valid && !ready;
      prev_tup   = cur_tup;
    end
  end

  task automatic run(input bit n3, input logic [63:0] ka, kb, kc, input logic m,
                     input int pat, input bit exp_perr, input bit glitch);
    int fv = -1;
    int dc = -1;
    int pc = -1;
    int cyc;
    int nk = n3 ? 3 : 1;
    @(negedge clk);
    sel3 = n3; k1v = ka; k2v = kb; k3v = kc; mode = m;
    got.delete();
    if (!exp_perr) push_sched(n3, ka, kb, kc, m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    ready = rdy(pat, 0);
    check("busy_after_start", 64'(cur_busy), 64'd1);
    while (cyc < 400 && dc < 0 && pc < 0) begin
      @(posedge clk); #1;
      cyc++;
      if (cur_valid && fv < 0) fv = cyc;
      if (cur_done) dc = cyc;
      if (cur_perr) pc = cyc;
      ready = rdy(pat, cyc - 1);
      if (glitch && cyc == 5) begin
        start = 1'b1; mode = ~m; k1v = ~ka; k3v = ~kc;
      end
      if (glitch && cyc == 6) start = 1'b0;
    end
    if (exp_perr) begin
      check("parity_err_cycle", 64'(pc), 64'd2);
      check("parity_no_valid", 64'(fv < 0), 64'd1);
      seen = 1'b0;
      repeat (20) begin
        @(posedge clk); #1;
        seen |= cur_valid | cur_done | cur_perr | cur_busy;
      end
      check("parity_then_quiet", 64'(seen), 64'd0);
    end else begin
      check("first_valid_cycle", 64'(fv), 64'd2);
      if (pat == 0) check("done_cycle", 64'(dc), 64'(17 * nk + 2));
      else          check("done_seen", 64'(dc > 0), 64'd1);
      check("busy_low_at_done", 64'(cur_busy), 64'd0);
      check("no_parity_err", 64'(pc < 0), 64'd1);
      check("queue_drained", 64'(q.size()), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ka, za;
    ka = 64'h133457799BBCDFF1;
    za = 64'h0101010101010101;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; ready = 1'b0; sel3 = 1'b0;
    k1v = '0; k2v = '0; k3v = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs_des", 64'(all1), 64'd0);
    check("reset_outputs_3des", 64'(all3), 64'd0);
    rst_n = 1'b1;

    run(1'b0, ka, '0, '0, 1'b0, 0, 1'b0, 1'b0);
    check("enc_k1", 64'(got[0]), 64'h1B02EFFC7072);
    check("enc_k2", 64'(got[1]), 64'h79AED9DBC9E5);
    check("enc_k16", 64'(got[15]), 64'hCB3D8B0E17F5);

    run(1'b0, ka, '0, '0, 1'b1, 0, 1'b0, 1'b0);
    check("dec_first", 64'(got[0]), 64'hCB3D8B0E17F5);
    check("dec_last", 64'(got[15]), 64'h1B02EFFC7072);

    run(1'b0, ka, '0, '0, 1'b0, 1, 1'b0, 1'b0);
    check("stall_count", 64'(got.size()), 64'd16);

    run(1'b1, ka, za, ka, 1'b0, 0, 1'b0, 1'b0);
    check("ede_stage0_first", 64'(got[0]), 64'h1B02EFFC7072);
    check("ede_stage1_zero", 64'(got[16]), 64'h0);
    check("ede_stage2_first", 64'(got[32]), 64'h1B02EFFC7072);

    run(1'b1, ka, za, ka, 1'b1, 0, 1'b0, 1'b0);
    check("ded_stage0_k3_dec", 64'(got[0]), 64'hCB3D8B0E17F5);

    for (int i = 0; i < 8; i++) begin
      run(1'($urandom_range(0, 1)), rand_key(), rand_key(), rand_key(),
          1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, 1'b0);
    end

    // Abort mid-schedule with reset, then confirm nothing else comes out.
    push_sched(1'b0, ka, '0, '0, 1'b0);
    @(negedge clk);
    sel3 = 1'b0; k1v = ka; mode = 1'b0; ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_abort_outputs", 64'(all1), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      seen |= v1 | done1 | busy1;
    end
    check("quiet_after_abort", 64'(seen), 64'd0);

    run(1'b0, ka, '0, '0, 1'b0, 0, 1'b0, 1'b1);
    check("restart_k1", 64'(got[0]), 64'h1B02EFFC7072);
    run(1'b1, rand_key(), rand_key(), rand_key(), 1'b1, 2, 1'b0, 1'b1);

    run(1'b0, 64'h123457799BBCDFF1, '0, '0, 1'b0, 0, ParityEn, 1'b0);
    run(1'b1, ka, 64'h0001010101010101, ka, 1'b0, 0, ParityEn, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
